// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;
  localparam int DEF_WIDTH = 18;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/div18_iter_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface div18_iter_if #(parameter int WIDTH = div_pkg::DEF_WIDTH);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (output start, signed_op, a, b,
                  input  busy, done, q, r, div_zero);
  modport slave  (input  start, signed_op, a, b,
                  output busy, done, q, r, div_zero);
endinterface

// File: rtl/div18_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div18_step #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    q_bit    = (shifted >= {2'b00, divisor});
    diff     = shifted[WIDTH:0] - {1'b0, divisor};
    rem_next = q_bit ? diff : shifted[WIDTH:0];
  end
endmodule

// File: rtl/div18_iter.sv
// Iterative restoring divider, one quotient bit per clock, fixed 19-edge latency.
// Define DIV_SIGNED_EN to honour signed_op (abs/negate and sign registers).
module div18_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  div18_iter_if.slave  io
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;      // dividend shifts out while quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic             dz;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

`ifdef DIV_SIGNED_EN
  logic             q_neg, r_neg;
`else
  logic             signed_unused;
  assign signed_unused = io.signed_op;
`endif

  div18_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      dz         <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
`ifdef DIV_SIGNED_EN
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
`ifdef DIV_SIGNED_EN
            q_neg <= io.signed_op & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            r_neg <= io.signed_op & io.a[WIDTH-1];
            dvd   <= (io.signed_op && io.a[WIDTH-1]) ? -io.a : io.a;
            dvs   <= (io.signed_op && io.b[WIDTH-1]) ? -io.b : io.b;
`else
            dvd   <= io.a;
            dvs   <= io.b;
`endif
            dz     <= (io.b == '0);
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor yields an all-ones magnitude; force it past the sign fix.
`ifdef DIV_SIGNED_EN
          q_q <= dz ? '1 : (q_neg ? -dvd : dvd);
          r_q <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`else
          q_q <= dz ? '1 : dvd;
          r_q <= rem[WIDTH-1:0];
`endif
          div_zero_q <= dz;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.q        = q_q;
  assign io.r        = r_q;
  assign io.div_zero = div_zero_q;
endmodule

// File: tb/tb_div18_iter.sv
// Randomized self-checking bench for div18_iter against an arithmetic reference model.
module tb_div18_iter;
  localparam int W = 18;
  localparam int LAT = 19;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  exp_t expq[$];

  div18_iter_if #(.WIDTH(W)) io ();
  div18_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb, qq, rr;
    bit     honour;
`ifdef DIV_SIGNED_EN
    honour = s;
`else
    honour = 1'b0;
`endif
    e.acc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      if (honour) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      qq = sa / sb;
      rr = sa % sb;
      e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Record every accepted request in program order.
  always @(posedge clk) begin
    edge_n++;
    if (rst_n && io.start && !io.busy) begin
      exp_t e;
      e = model(io.a, io.b, io.signed_op);
      e.acc = edge_n;
      expq.push_back(e);
    end
  end

  always @(negedge rst_n) expq.delete();

  // Compare process: handshake every cycle, results and latency on each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io.done) begin
        chk("busy_in_done", {31'b0, io.busy}, 32'd0);
        if (expq.size() == 0) begin
          chk("done_spurious", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("model_q", {14'b0, io.q}, {14'b0, e.q});
          chk("model_r", {14'b0, io.r}, {14'b0, e.r});
          chk("model_dz", {31'b0, io.div_zero}, {31'b0, e.dz});
          chk("model_latency", edge_n - e.acc, LAT);
        end
      end else begin
        chk("busy_track", {31'b0, io.busy}, {31'b0, expq.size() > 0});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    io.start = 1'b1; io.a = a; io.b = b; io.signed_op = s;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic wait_done(output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    bit got = 0;
    q = '0; r = '0; dz = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (io.done) begin
        got = 1; q = io.q; r = io.r; dz = io.div_zero;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz);
    logic [W-1:0] q, r;
    logic dz;
    issue(a, b, s);
    wait_done(q, r, dz);
    chk({name, "_q"}, {14'b0, q}, {14'b0, eq});
    chk({name, "_r"}, {14'b0, r}, {14'b0, er});
    chk({name, "_dz"}, {31'b0, dz}, {31'b0, edz});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q, r, ra, rb;
    logic dz, rs;
    rst_n = 1'b0;
    io.start = 1'b0; io.signed_op = 1'b0; io.a = '0; io.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, io.busy}, 32'd0);
    chk("rst_done", {31'b0, io.done}, 32'd0);
    chk("rst_q", {14'b0, io.q}, 32'd0);
    chk("rst_r", {14'b0, io.r}, 32'd0);
    chk("rst_dz", {31'b0, io.div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_lit("u100_7", 18'd100, 18'd7, 1'b0, 18'd14, 18'd2, 1'b0);
`ifdef DIV_SIGNED_EN
    run_lit("s_m100_7", 18'h3FF9C, 18'd7, 1'b1, 18'h3FFF2, 18'h3FFFE, 1'b0);
    run_lit("s_ovf", 18'h20000, 18'h3FFFF, 1'b1, 18'h20000, 18'd0, 1'b0);
`else
    run_lit("s_m100_7", 18'h3FF9C, 18'd7, 1'b1, 18'd37434, 18'd6, 1'b0);
    run_lit("s_ovf", 18'h20000, 18'h3FFFF, 1'b1, 18'd0, 18'h20000, 1'b0);
`endif
    run_lit("div0_s", 18'd1234, 18'd0, 1'b1, 18'h3FFFF, 18'd1234, 1'b1);
    run_lit("div0_u", 18'd1234, 18'd0, 1'b0, 18'h3FFFF, 18'd1234, 1'b1);
    run_lit("u_max_1", 18'h3FFFF, 18'd1, 1'b0, 18'h3FFFF, 18'd0, 1'b0);

    // Start while busy must be ignored and must not resample operands.
    issue(18'd1000, 18'd3, 1'b0);
    repeat (3) @(negedge clk);
    io.start = 1'b1; io.a = 18'd50; io.b = 18'd5;
    @(negedge clk);
    io.start = 1'b0;
    wait_done(q, r, dz);
    chk("busy_ign_q", {14'b0, q}, 32'd333);
    chk("busy_ign_r", {14'b0, r}, 32'd1);

    // Asynchronous reset mid-operation clears everything at once.
    issue(18'd500, 18'd9, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, io.busy}, 32'd0);
    chk("arst_done", {31'b0, io.done}, 32'd0);
    chk("arst_q", {14'b0, io.q}, 32'd0);
    chk("arst_r", {14'b0, io.r}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_lit("post_rst", 18'd77, 18'd8, 1'b0, 18'd9, 18'd5, 1'b0);

    // Back-to-back: new start driven in the done cycle.
    issue(18'd100, 18'd7, 1'b0);
    wait_done(q, r, dz);
    io.start = 1'b1; io.a = 18'd9; io.b = 18'd2; io.signed_op = 1'b0;
    @(negedge clk);
    io.start = 1'b0;
    chk("b2b_pulse_len", {31'b0, io.done}, 32'd0);
    chk("b2b_busy", {31'b0, io.busy}, 32'd1);
    wait_done(q, r, dz);
    chk("b2b_q", {14'b0, q}, 32'd4);
    chk("b2b_r", {14'b0, r}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 3));
        2: rb = '1;
        3: ra = 18'h20000;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      wait_done(q, r, dz);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
